// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: two-port arbiter onto a word-wide data memory with sub-word load extraction and read-modify-write stores.
module dmem_access_arbiter #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0] state, size, a_size;
  logic last, port, we, uns, err;
  logic [31:0] addr, wdata, word, a_addr, a_wdata, lane, mask, merged, loaded;
  logic g0, g1, acc, a_we, a_uns, a_err;
  logic [4:0] sh;
  always_comb begin
    g1 = req1_valid && (!req0_valid || (RR_ENABLE && !last));
    g0 = req0_valid && !g1;
    req0_ready = state == IDLE && !rst && g0;
    req1_ready = state == IDLE && !rst && g1;
    acc = req0_ready || req1_ready;
    a_we = g1 ? req1_we : req0_we;
    a_size = g1 ? req1_size : req0_size;
    a_uns = g1 ? req1_unsigned : req0_unsigned;
    a_addr = g1 ? req1_addr : req0_addr;
    a_wdata = g1 ? req1_wdata : req0_wdata;
    a_err = a_size == 2'b11 || (a_size == 2'b01 && a_addr[0]) ||
            (a_size == 2'b10 && a_addr[1:0] != 2'b00) ||
            {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
    sh = {addr[1:0], 3'b000};
    lane = mem_rdata >> sh;
    mask = size == 2'b00 ? 32'hFF << sh : size == 2'b01 ? 32'hFFFF << sh : 32'hFFFF_FFFF;
    merged = (mem_rdata & ~mask) | ((wdata << sh) & mask);
    loaded = size == 2'b00 ? {{24{!uns && lane[7]}}, lane[7:0]} :
             size == 2'b01 ? {{16{!uns && lane[15]}}, lane[15:0]} : lane;
    mem_we = state == WRITE;
    mem_wdata = mem_we ? word : 32'h0;
    rsp0_valid = state == RESP && !port;
    rsp1_valid = state == RESP && port;
    rsp0_err = rsp0_valid && err;
    rsp1_err = rsp1_valid && err;
    rsp0_rdata = rsp0_valid && !we ? word : 32'h0;
    rsp1_rdata = rsp1_valid && !we ? word : 32'h0;
  end
  // Errors still pass through READ (without touching memory) so every non-store response lands two cycles after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      port <= 1'b0;
      we <= 1'b0;
      size <= 2'b00;
      uns <= 1'b0;
      err <= 1'b0;
      addr <= 32'h0;
      wdata <= 32'h0;
      word <= 32'h0;
      mem_addr <= 32'h0;
    end else if (state == IDLE) begin
      if (acc) begin
        port <= g1;
        last <= g1;
        we <= a_we;
        size <= a_size;
        uns <= a_uns;
        addr <= a_addr;
        wdata <= a_wdata;
        err <= a_err;
        word <= a_err ? 32'h0 : a_wdata;
        if (!a_err) mem_addr <= {a_addr[31:2], 2'b00};
        state <= (a_err || !a_we || a_size != 2'b10) ? READ : WRITE;
      end
    end else if (state == READ) begin
      word <= err ? 32'h0 : we ? merged : loaded;
      state <= (we && !err) ? WRITE : RESP;
    end else begin
      state <= state == WRITE ? RESP : IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: directed checks of arbitration, latency, lane handling, errors and mid-transaction reset.
module tb_dmem_access_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_we = 0, req0_unsigned = 0, req1_valid = 0, req1_we = 0, req1_unsigned = 0;
  logic [1:0] req0_size = 0, req1_size = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, mem_we;
  logic [31:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic f_r0, f_r1, f_v0, f_e0, f_v1, f_e1, f_we;
  logic [31:0] f_d0, f_d1, f_ma, f_wd;
  logic [31:0] tmem [0:1023];
  int n_chk = 0, n_fail = 0, cyc = 0, acc = 0;
  int we_cnt, we_cyc, rsp_cnt, rsp_cyc;
  logic [31:0] we_addr, we_data, rsp_data;
  logic rsp_port, rsp_err;

  dmem_access_arbiter #(.DEPTH_WORDS(1024), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  dmem_access_arbiter #(.DEPTH_WORDS(1024), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_r0), .req0_we(req0_we), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(f_r1), .req1_we(req1_we), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(f_v0), .rsp0_rdata(f_d0), .rsp0_err(f_e0),
    .rsp1_valid(f_v1), .rsp1_rdata(f_d1), .rsp1_err(f_e1),
    .mem_addr(f_ma), .mem_wdata(f_wd), .mem_we(f_we), .mem_rdata(32'h0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = tmem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) tmem[mem_addr[11:2]] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1; we_cyc <= cyc; we_addr <= mem_addr; we_data <= mem_wdata;
    end
    if (rsp0_valid || rsp1_valid) begin
      rsp_cnt <= rsp_cnt + 1; rsp_cyc <= cyc; rsp_port <= rsp1_valid;
      rsp_data <= rsp1_valid ? rsp1_rdata : rsp0_rdata;
      rsp_err <= rsp1_valid ? rsp1_err : rsp0_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start(input int p, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    we_cnt = 0; rsp_cnt = 0;
    @(posedge clk); #1;
    if (p == 0) begin
      req0_valid = 1; req0_we = w; req0_size = s; req0_unsigned = u; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1; req1_we = w; req1_size = s; req1_unsigned = u; req1_addr = a; req1_wdata = d;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin ok = 1; acc = cyc; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic xact(input int p, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    start(p, w, s, u, a, d);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] exp);
    xact(0, 0, s, u, a, 0);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_lat"}, rsp_cyc - acc, 2);
    check({tag, "_nowe"}, we_cnt, 0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [1:0] s, input logic [31:0] a);
    xact(1, w, s, 0, a, 32'hFFFF_FFFF);
    check({tag, "_err"}, rsp_err, 1);
    check({tag, "_data"}, rsp_data, 0);
    check({tag, "_nowe"}, we_cnt, 0);
    check({tag, "_lat"}, rsp_cyc - acc, 2);
  endtask

  initial begin
    int g[2][4];
    int n[2];
    for (int i = 0; i < 1024; i++) tmem[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
    #1 rst = 0;

    xact(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    check("wst_we_cnt", we_cnt, 1);
    check("wst_we_lat", we_cyc - acc, 1);
    check("wst_addr", we_addr, 32'h10);
    check("wst_data", we_data, 32'hDEADBEEF);
    check("wst_rsp_lat", rsp_cyc - acc, 2);
    check("wst_rsp", {rsp_cnt[3:0], rsp_port, rsp_err}, {4'd1, 1'b0, 1'b0});

    load_chk("lb_s", 2'b00, 0, 32'h13, 32'hFFFFFFDE);
    load_chk("lb_u", 2'b00, 1, 32'h13, 32'h000000DE);

    xact(1, 1, 2'b01, 0, 32'h12, 32'h0000_1234);
    check("hst_we_cnt", we_cnt, 1);
    check("hst_data", we_data, 32'h1234BEEF);
    check("hst_we_lat", we_cyc - acc, 2);
    check("hst_rsp_lat", rsp_cyc - acc, 3);
    check("hst_port", rsp_port, 1);

    load_chk("lw", 2'b10, 0, 32'h10, 32'h1234BEEF);
    load_chk("lh_s", 2'b01, 0, 32'h10, 32'hFFFFBEEF);
    load_chk("lh_u", 2'b01, 1, 32'h10, 32'h0000BEEF);
    load_chk("lb_1", 2'b00, 0, 32'h11, 32'hFFFFFFBE);

    xact(0, 1, 2'b00, 0, 32'h11, 32'h0000_00A5);
    check("bst_data", we_data, 32'h1234A5EF);

    err_chk("e_word", 0, 2'b10, 32'h02);
    err_chk("e_half", 0, 2'b01, 32'h01);
    err_chk("e_size", 0, 2'b11, 32'h00);
    err_chk("e_range", 0, 2'b10, 32'h1000);
    err_chk("e_st_range", 1, 2'b10, 32'h1000);

    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    req0_valid = 1; req0_we = 0; req0_size = 2'b10; req0_addr = 32'h10;
    req1_valid = 1; req1_we = 0; req1_size = 2'b10; req1_addr = 32'h10;
    n = '{0, 0};
    for (int i = 0; i < 40 && (n[0] < 4 || n[1] < 4); i++) begin
      @(negedge clk);
      if (n[0] < 4 && (req0_ready || req1_ready)) begin g[0][n[0]] = req1_ready ? 1 : 0; n[0]++; end
      if (n[1] < 4 && (f_r0 || f_r1)) begin g[1][n[1]] = f_r1 ? 1 : 0; n[1]++; end
    end
    check("rr_count", n[0], 4);
    check("fp_count", n[1], 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), n[0] > k ? g[0][k] : 9, k % 2);
      check($sformatf("fp_grant%0d", k), n[1] > k ? g[1][k] : 9, 0);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    xact(1, 0, 2'b10, 0, 32'h10, 0);
    start(1, 1, 2'b00, 0, 32'h10, 32'h77);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_nowe", we_cnt, 0);
    check("mid_rst_norsp", rsp_cnt, 0);
    check("mid_rst_mem", tmem[4], 32'h1234A5EF);
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("mid_rst_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
